// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types only). Backpressure: n/a.
package HighLevelControl;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } hazState;

  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard unit.
// master = hazard unit (drives stall/flush), slave = pipeline stage registers.
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           Rs1D;
  logic [4:0]           Rs2D;
  logic [4:0]           RdE;
  logic                 MemReadE;
  logic                 MulDivStartE;
  logic                 PCSrcE;
  logic                 TrapM;
  logic                 MemStallM;
  logic                 StallF;
  logic                 StallD;
  logic                 StallE;
  logic                 StallM;
  logic                 FlushD;
  logic                 FlushE;
  logic                 FlushM;
  logic                 BusyE;
  logic                 DoneE;
  logic [CNT_WIDTH-1:0] StallCount;

  modport master (
    input  Rs1D, Rs2D, RdE, MemReadE, MulDivStartE, PCSrcE, TrapM, MemStallM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
           BusyE, DoneE, StallCount
  );

  modport slave (
    output Rs1D, Rs2D, RdE, MemReadE, MulDivStartE, PCSrcE, TrapM, MemStallM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
           BusyE, DoneE, StallCount
  );
endinterface

// File: rtl/hazard_ctrl_muldiv_timer.sv
// Down-counter sequencing multi-cycle E-stage ops; 1-cycle update, zero flag combinational.
// Priority: clear > hold > load > decrement.
module hazard_muldiv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         hold,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (hold)  cnt <= cnt;
    else if (load)  cnt <= load_val;
    else if (dec)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline; outputs are combinational from state+inputs.
// Memory stall freezes everything; trap overrides all and aborts a multi-cycle op.
module hazard_ctrl
  import HighLevelControl::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master hz
);

  localparam int CW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;

  hazState state, next_state;
  logic [CW-1:0] cnt;
  logic cnt_zero, t_clr, t_hold, t_load, t_dec;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, done_e;
  logic [CNT_WIDTH-1:0] stall_count;

  hazard_muldiv_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (t_clr),
    .hold     (t_hold),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (CW'(MULDIV_LATENCY - 2)),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    t_clr   = 1'b0;
    t_hold  = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    done_e  = 1'b0;
    if (hz.TrapM) begin
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      flush_m    = 1'b1;
      next_state = RUN;
      t_clr      = 1'b1;
    end else if (hz.MemStallM) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      t_hold  = 1'b1;
    end else if (state == MULTI) begin
      // Branch redirect is ignored here: E still holds the mul/div op.
      if (!cnt_zero) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        t_dec   = 1'b1;
      end else begin
        done_e     = 1'b1;
        next_state = RUN;
      end
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz.MulDivStartE) begin
      stall_f    = 1'b1;
      stall_d    = 1'b1;
      stall_e    = 1'b1;
      flush_m    = 1'b1;
      next_state = MULTI;
      t_load     = 1'b1;
    end else if (load_use_hit(hz.MemReadE, hz.RdE, hz.Rs1D, hz.Rs2D)) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        stall_count <= '0;
    else if (stall_f) stall_count <= stall_count + CNT_WIDTH'(1);
  end

  // Reset must silence every pin immediately, including the combinational ones.
  assign hz.StallF     = stall_f & ~reset;
  assign hz.StallD     = stall_d & ~reset;
  assign hz.StallE     = stall_e & ~reset;
  assign hz.StallM     = stall_m & ~reset;
  assign hz.FlushD     = flush_d & ~reset;
  assign hz.FlushE     = flush_e & ~reset;
  assign hz.FlushM     = flush_m & ~reset;
  assign hz.DoneE      = done_e & ~reset;
  assign hz.BusyE      = (state == MULTI);
  assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: age-based reference model checked every negedge plus literal pins.
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CNTW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  hazard_ctrl_if #(.CNT_WIDTH(CNTW)) hif();

  hazard_ctrl #(.MULDIV_LATENCY(LAT), .CNT_WIDTH(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  // Model: m_age = E-cycles elapsed in the current multi-cycle op (0 = none in flight).
  int          m_age;
  logic [31:0] m_cnt;

  // order: StallF StallD StallE StallM FlushD FlushE FlushM BusyE DoneE
  function automatic logic [8:0] model_out();
    logic sf, sd, se, sm, fd, fe, fm, bz, dn, lu;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fm = 0; dn = 0;
    bz = (m_age != 0);
    lu = hif.MemReadE && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
    if (reset) return 9'd0;
    if (hif.TrapM) begin
      fd = 1; fe = 1; fm = 1;
    end else if (hif.MemStallM) begin
      sf = 1; sd = 1; se = 1; sm = 1;
    end else if (m_age != 0) begin
      if (m_age < LAT) begin sf = 1; sd = 1; se = 1; fm = 1; end
      else dn = 1;
    end else if (hif.PCSrcE) begin
      fd = 1; fe = 1;
    end else if (hif.MulDivStartE) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end else if (lu) begin
      sf = 1; sd = 1; fe = 1;
    end
    return {sf, sd, se, sm, fd, fe, fm, bz, dn};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age <= 0;
      m_cnt <= '0;
    end else begin
      logic [8:0] e;
      e = model_out();
      if (e[8]) m_cnt <= m_cnt + 1;
      if (hif.TrapM) m_age <= 0;
      else if (hif.MemStallM) m_age <= m_age;
      else if (m_age != 0) m_age <= (m_age == LAT) ? 0 : m_age + 1;
      else if (!hif.PCSrcE && hif.MulDivStartE) m_age <= 2;
    end
  end

  always @(negedge clk) begin
    logic [8:0] d, e;
    d = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
         hif.FlushM, hif.BusyE, hif.DoneE};
    e = model_out();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL model_outputs t=%0t got %b expected %b", $time, d, e);
    end
    checks++;
    if (hif.StallCount !== m_cnt) begin
      errors++;
      $display("FAIL model_stallcount t=%0t got %0d expected %0d", $time, hif.StallCount, m_cnt);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_in();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.RdE = 0; hif.MemReadE = 0;
    hif.MulDivStartE = 0; hif.PCSrcE = 0; hif.TrapM = 0; hif.MemStallM = 0;
  endtask

  // Move to 1 time unit after the next rising edge, where inputs are changed.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_seq(input logic [31:0] base);
    hif.MemReadE = 1; hif.RdE = 5; hif.Rs1D = 5;
    @(negedge clk);
    lit("lu_stallf", hif.StallF, 1);
    lit("lu_stalld", hif.StallD, 1);
    lit("lu_flushe", hif.FlushE, 1);
    next_cyc();
    clear_in();
    @(negedge clk);
    lit("lu_one_cycle", hif.StallF, 0);
    lit("lu_count", hif.StallCount, base + 1);
  endtask

  initial begin
    clear_in();
    @(negedge clk);
    @(negedge clk);
    lit("rst_count", hif.StallCount, 0);
    lit("rst_busy", hif.BusyE, 0);
    next_cyc();
    reset = 0;

    // load-use hit, then the same with RdE = x0
    next_cyc();
    load_use_seq(0);
    next_cyc();
    hif.MemReadE = 1; hif.RdE = 0; hif.Rs1D = 0;
    @(negedge clk);
    lit("lu_x0_stallf", hif.StallF, 0);
    next_cyc();
    clear_in();
    @(negedge clk);
    lit("lu_x0_count", hif.StallCount, 1);

    // mul/div with start held for the whole op
    next_cyc();
    hif.MulDivStartE = 1;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      lit($sformatf("md_stallf_c%0d", c), hif.StallF, (c < LAT) ? 1 : 0);
      lit($sformatf("md_flushm_c%0d", c), hif.FlushM, (c < LAT) ? 1 : 0);
      lit($sformatf("md_busy_c%0d", c), hif.BusyE, (c >= 2) ? 1 : 0);
      lit($sformatf("md_done_c%0d", c), hif.DoneE, (c == LAT) ? 1 : 0);
      next_cyc();
    end
    clear_in();
    @(negedge clk);
    lit("md_count", hif.StallCount, 4);
    lit("md_idle_busy", hif.BusyE, 0);

    // branch redirect beats a concurrent load-use hit
    next_cyc();
    hif.PCSrcE = 1; hif.MemReadE = 1; hif.RdE = 3; hif.Rs2D = 3;
    @(negedge clk);
    lit("br_flushd", hif.FlushD, 1);
    lit("br_flushe", hif.FlushE, 1);
    lit("br_stallf", hif.StallF, 0);
    next_cyc();
    clear_in();
    @(negedge clk);
    lit("br_count", hif.StallCount, 4);

    // trap while cnt = 1 (third cycle of the op)
    next_cyc();
    hif.MulDivStartE = 1;
    next_cyc();
    next_cyc();
    hif.TrapM = 1;
    @(negedge clk);
    lit("trap_flushd", hif.FlushD, 1);
    lit("trap_flushm", hif.FlushM, 1);
    lit("trap_stallf", hif.StallF, 0);
    lit("trap_done", hif.DoneE, 0);
    next_cyc();
    clear_in();
    @(negedge clk);
    lit("trap_busy_after", hif.BusyE, 0);
    lit("trap_done_after", hif.DoneE, 0);
    lit("trap_count", hif.StallCount, 6);

    // memory freeze for two cycles at cnt = 1
    next_cyc();
    hif.MulDivStartE = 1;
    next_cyc();
    next_cyc();
    hif.MemStallM = 1;
    @(negedge clk);
    lit("mem_stallm", hif.StallM, 1);
    lit("mem_stalle", hif.StallE, 1);
    lit("mem_done_c3", hif.DoneE, 0);
    next_cyc();
    @(negedge clk);
    lit("mem_done_c4", hif.DoneE, 0);
    next_cyc();
    hif.MemStallM = 0;
    @(negedge clk);
    lit("mem_stallf_c5", hif.StallF, 1);
    lit("mem_done_c5", hif.DoneE, 0);
    next_cyc();
    @(negedge clk);
    lit("mem_done_c6", hif.DoneE, 1);
    next_cyc();
    clear_in();
    @(negedge clk);
    lit("mem_count", hif.StallCount, 11);

    // async reset mid-cycle during MULTI
    next_cyc();
    hif.MulDivStartE = 1;
    next_cyc();
    #1;
    reset = 1;
    #1;
    lit("arst_busy", hif.BusyE, 0);
    lit("arst_stallf", hif.StallF, 0);
    lit("arst_flushm", hif.FlushM, 0);
    lit("arst_count", hif.StallCount, 0);
    #1;
    reset = 0;
    clear_in();
    next_cyc();
    load_use_seq(0);

    next_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush generator for the 5-stage pipeline (F, D, E, M, W). It drives the stall and flush pins of the stage registers (flopRS/flopRF/flopRFS) and sequences multi-cycle execute operations with an internal down-counter. It also keeps a running stall-cycle count, which the CSR block exposes as a performance counter.

Parameters:
MULDIV_LATENCY, 4, total E-stage cycles of a multi-cycle op (legal range >= 2)
CNT_WIDTH, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
Rs1D  in  5  source reg 1 of instruction in D
Rs2D  in  5  source reg 2 of instruction in D
RdE  in  5  destination reg of instruction in E
MemReadE  in  1  instruction in E is a load
MulDivStartE  in  1  instruction in E is a multi-cycle op (held high while E is stalled)
PCSrcE  in  1  taken branch or jump redirect resolved in E
TrapM  in  1  exception or trap taken in M
MemStallM  in  1  data memory not ready; freeze the pipeline
StallF, StallD, StallE, StallM  out  1 each  stage-register hold
FlushD, FlushE, FlushM  out  1 each  stage-register bubble insert
BusyE  out  1  multi-cycle op in progress (state MULTI)
DoneE  out  1  one-cycle pulse: multi-cycle result valid this cycle
StallCount  out  CNT_WIDTH  cycles in which StallF was asserted

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. Assertion forces state RUN, count 0, StallCount 0 and all outputs 0 immediately, with no clock edge needed.
- State is the HighLevelControl::hazState enum, with values RUN and MULTI, plus a down-counter cnt of width $clog2(MULDIV_LATENCY).
- Priority, highest first, evaluated combinationally each cycle:
  1. TrapM
  2. MemStallM
  3. MULTI hold
  4. PCSrcE
  5. multi-cycle start
  6. load-use
- TrapM:
  - Drives FlushD=FlushE=FlushM=1 and all stalls 0.
  - Next state is RUN and cnt becomes 0.
  - A MULTI in progress is aborted and DoneE is not pulsed.
- MemStallM (no TrapM):
  - Drives StallF=StallD=StallE=StallM=1 and all flushes 0.
  - State and cnt are frozen (no decrement).
  - DoneE is 0; a pending completion is deferred.
- MULTI, cnt != 0:
  - Drives StallF=StallD=StallE=1 and FlushM=1 (bubble into M).
  - cnt decrements by 1.
- MULTI, cnt == 0:
  - No stall or flush from this rule; DoneE=1.
  - Next state is RUN.
  - PCSrcE is ignored in MULTI because E holds the mul/div op.
- RUN with PCSrcE: drives FlushD=FlushE=1 with no stall. This also wins over a load-use hit.
- RUN with MulDivStartE:
  - Drives StallF=StallD=StallE=1 and FlushM=1.
  - Next state is MULTI and cnt loads MULDIV_LATENCY-2.
  - Net effect: MULDIV_LATENCY-1 stall cycles, then DoneE in cycle MULDIV_LATENCY.
- RUN with load-use:
  - Condition: MemReadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - Drives StallF=StallD=1 and FlushE=1, for exactly one cycle.
- BusyE = (state == MULTI).
- StallCount increments by 1 on each posedge where StallF=1. It wraps to 0 at 2^CNT_WIDTH-1 and has no saturation.
- StallM is driven only by MemStallM.

Decomposition:
- HighLevelControl package: the hazState enum (RUN, MULTI).
- Sub-module hazard_muldiv_timer: async-reset down-counter with load, decrement, hold and clear inputs, and a zero flag. Width is $clog2(MULDIV_LATENCY).
- The priority logic and StallCount register stay in hazard_ctrl.

Test Plan:
- Load-use: MemReadE=1, RdE=5, Rs1D=5, one cycle -> StallF=StallD=FlushE=1 for 1 cycle, StallCount 0->1. Same stimulus with RdE=0 -> no stall, StallCount stays 0.
- Mul/div, LATENCY=4: MulDivStartE=1 held -> StallF/D/E=1 and FlushM=1 for cycles 1-3, BusyE=1 for cycles 2-4, DoneE=1 in cycle 4 only, StallCount +3.
- Branch: PCSrcE=1 in RUN, with a concurrent load-use hit -> FlushD=FlushE=1, StallF=0, StallCount unchanged.
- Trap mid-op: start mul/div, then assert TrapM when cnt=1 -> FlushD/E/M=1 that cycle, BusyE=0 on the next cycle, DoneE never pulses.
- Memory freeze: MemStallM=1 for 2 cycles during MULTI at cnt=1 -> cnt holds at 1, all four stalls=1, DoneE arrives 2 cycles later than without MemStallM.
- Async reset: assert reset between clock edges during MULTI -> BusyE, all stalls and flushes, and StallCount read 0 before the next posedge; after release, a load-use stimulus behaves as in the first scenario.
